// File: rtl/pim_cmd_issuer_if.sv
// Host-facing command/response port and memory-facing start/done port of pim_cmd_issuer.
interface pim_cmd_issuer_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src1;
  logic [ADDR_W-1:0] cmd_src2;
  logic [ADDR_W-1:0] cmd_dst;

  logic [ADDR_W-1:0] src1_addr;
  logic [ADDR_W-1:0] src2_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              start;
  logic              done;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_error;
  logic [31:0]       resp_cycles;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_src1, cmd_src2, cmd_dst, done, resp_ready,
    output cmd_ready, src1_addr, src2_addr, dst_addr, start,
           resp_valid, resp_error, resp_cycles, busy
  );

  modport master (
    output cmd_valid, cmd_src1, cmd_src2, cmd_dst, done, resp_ready,
    input  cmd_ready, src1_addr, src2_addr, dst_addr, start,
           resp_valid, resp_error, resp_cycles, busy
  );
endinterface

// File: rtl/pim_cmd_issuer.sv
// Buffers host matrix-multiply commands in a FIFO and issues them one at a time to the
// PIM memory over start/done, returning a cycle count and timeout flag per command.
module pim_cmd_issuer #(
  parameter int          DEPTH          = 4,
  parameter int          ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  pim_cmd_issuer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C   = DEPTH[PTR_W:0];
  localparam logic [31:0]    TIMEOUT_C = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
  } cmd_t;

  cmd_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic [31:0]      cycle_cnt;
  logic             push, pop;
  cmd_t             head;

  // NOTE: cmd_ready looks only at the registered count, so a pop in the same cycle
  // does not let a push through; this keeps ready free of any path from the FSM.
  assign bus.cmd_ready = (count != DEPTH_C);
  assign bus.busy      = (state != S_IDLE) || (count != '0);

  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = fifo_mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is tracked by count alone, and
  // leaving the array out of the reset keeps it mappable to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{src1: bus.cmd_src1, src2: bus.cmd_src2, dst: bus.cmd_dst};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cycle_cnt       <= '0;
      bus.start       <= 1'b0;
      bus.src1_addr   <= '0;
      bus.src2_addr   <= '0;
      bus.dst_addr    <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_error  <= 1'b0;
      bus.resp_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.src1_addr <= head.src1;
            bus.src2_addr <= head.src2;
            bus.dst_addr  <= head.dst;
            bus.start     <= 1'b1;
            cycle_cnt     <= 32'd1;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          // done takes priority over a timeout landing on the same cycle
          if (bus.done || cycle_cnt == TIMEOUT_C) begin
            bus.start       <= 1'b0;
            bus.resp_valid  <= 1'b1;
            bus.resp_cycles <= cycle_cnt;
            bus.resp_error  <= !bus.done;
            state           <= S_RESP;
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
